// File: rtl/snoop_loader_if.sv
// Byte-stream input and discus snoop-port bundle used by the program loader.
interface snoop_loader_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    // Host/UART byte stream (valid/ready)
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    // Snoop port towards the discus core
    logic [AW-1:0] snoopa;
    logic [DW-1:0] snoopd;
    logic          snoopm;
    logic          snoopw;
    logic [DW-1:0] snoopq;
    logic          snoopp;
    logic          core_reset;

    // Loader side: consumes the stream and drives the snoop port
    modport master (
        input  in_valid,
        input  in_data,
        input  snoopq,
        output in_ready,
        output snoopa,
        output snoopd,
        output snoopm,
        output snoopw,
        output snoopp,
        output core_reset
    );

    // Environment side: byte source plus core/memory
    modport slave (
        output in_valid,
        output in_data,
        output snoopq,
        input  in_ready,
        input  snoopa,
        input  snoopd,
        input  snoopm,
        input  snoopw,
        input  snoopp,
        input  core_reset
    );
endinterface

// File: rtl/snoop_loader.sv
// Program loader: writes a contiguous image from a byte stream into the discus core
// through its snoop port, optionally verifying each word, then releases the core.
module snoop_loader #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned LW        = 9,
    parameter int unsigned VERIFY    = 1,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned SKIP_ZERO = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    snoop_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_addr
);

    localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WRITE   = 3'd2,
        S_RDWAIT  = 3'd3,
        S_CHECK   = 3'd4,
        S_RELEASE = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t          state;
    state_t          state_next;

    // Datapath registers
    logic [AW-1:0]    addr;
    logic [LW-1:0]    cnt;
    logic [DW-1:0]    data;
    logic [LAT_W-1:0] lat_cnt;

    // Registered outputs
    logic             in_ready_r;
    logic [AW-1:0]    snoopa_r;
    logic [DW-1:0]    snoopd_r;
    logic             snoopm_r;
    logic             snoopw_r;
    logic             snoopp_r;
    logic             core_reset_r;

    // Next values produced by the output process
    logic [AW-1:0]    addr_d;
    logic [LW-1:0]    cnt_d;
    logic [DW-1:0]    data_d;
    logic [LAT_W-1:0] lat_d;
    logic             in_ready_d;
    logic [AW-1:0]    snoopa_d;
    logic [DW-1:0]    snoopd_d;
    logic             snoopm_d;
    logic             snoopw_d;
    logic             hold_core_d;
    logic             busy_d;
    logic             done_d;
    logic             error_d;
    logic [AW-1:0]    err_addr_d;
    logic             advance;

    // Shared decode terms
    logic             xfer;
    logic             last;
    logic             is_zero;
    logic             skip;
    logic             match;
    logic             idle_like;

    assign xfer      = bus.in_valid & in_ready_r;
    assign last      = (cnt == LW'(1));
    assign is_zero   = (bus.in_data == '0);
    assign skip      = (SKIP_ZERO != 0) && is_zero;
    assign match     = (bus.snoopq == data);
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

    assign bus.in_ready   = in_ready_r;
    assign bus.snoopa     = snoopa_r;
    assign bus.snoopd     = snoopd_r;
    assign bus.snoopm     = snoopm_r;
    assign bus.snoopw     = snoopw_r;
    assign bus.snoopp     = snoopp_r;
    assign bus.core_reset = core_reset_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = (len == '0) ? S_RELEASE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (xfer) begin
                    if (skip) begin
                        state_next = last ? S_RELEASE : S_FETCH;
                    end else begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (VERIFY != 0) begin
                    state_next = S_RDWAIT;
                end else begin
                    state_next = last ? S_RELEASE : S_FETCH;
                end
            end
            S_RDWAIT: begin
                if (lat_cnt == '0) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (match) begin
                    state_next = last ? S_RELEASE : S_FETCH;
                end else begin
                    state_next = S_ERROR;
                end
            end
            S_RELEASE: state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath and output next values, aligned with the state being entered
    always_comb begin
        advance    = 1'b0;
        addr_d     = addr;
        cnt_d      = cnt;
        data_d     = data;
        lat_d      = lat_cnt;
        err_addr_d = err_addr;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    addr_d = base;
                    cnt_d  = len;
                end
            end
            S_FETCH: begin
                if (xfer) begin
                    data_d  = bus.in_data;
                    advance = skip;
                end
            end
            S_WRITE: begin
                lat_d   = LAT_W'(READ_LAT - 1);
                advance = (VERIFY == 0);
            end
            S_RDWAIT: begin
                if (lat_cnt != '0) begin
                    lat_d = lat_cnt - LAT_W'(1);
                end
            end
            S_CHECK: begin
                if (match) begin
                    advance = 1'b1;
                end else begin
                    err_addr_d = addr;
                end
            end
            default: ;
        endcase

        // Address wraps naturally at 2**AW
        if (advance) begin
            addr_d = addr + AW'(1);
            cnt_d  = cnt - LW'(1);
        end

        in_ready_d = (state_next == S_FETCH);
        snoopa_d   = snoopa_r;
        snoopd_d   = snoopd_r;
        snoopm_d   = 1'b0;
        snoopw_d   = 1'b0;
        if (state_next == S_WRITE) begin
            snoopa_d = addr_d;
            snoopd_d = data_d;
            snoopw_d = 1'b1;
        end else if (state_next == S_RDWAIT) begin
            snoopa_d = addr_d;
            snoopm_d = 1'b1;
        end

        // Core is released only on the way to, and while in, DONE
        hold_core_d = !((state_next == S_RELEASE) || (state_next == S_DONE));
        busy_d      = !((state_next == S_IDLE) || (state_next == S_DONE) ||
                        (state_next == S_ERROR));
        done_d      = (state_next == S_DONE);
        error_d     = (state_next == S_ERROR);

        // A start that is not accepted must not disturb anything
        if (!idle_like && start) begin
            addr_d = addr_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr         <= '0;
            cnt          <= '0;
            data         <= '0;
            lat_cnt      <= '0;
            in_ready_r   <= 1'b0;
            snoopa_r     <= '0;
            snoopd_r     <= '0;
            snoopm_r     <= 1'b0;
            snoopw_r     <= 1'b0;
            snoopp_r     <= 1'b1;
            core_reset_r <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_addr     <= '0;
        end else begin
            addr         <= addr_d;
            cnt          <= cnt_d;
            data         <= data_d;
            lat_cnt      <= lat_d;
            in_ready_r   <= in_ready_d;
            snoopa_r     <= snoopa_d;
            snoopd_r     <= snoopd_d;
            snoopm_r     <= snoopm_d;
            snoopw_r     <= snoopw_d;
            snoopp_r     <= hold_core_d;
            core_reset_r <= hold_core_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            err_addr     <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_snoop_loader.sv
// Directed bench for snoop_loader: a write scoreboard filled as words are streamed,
// a snoop memory model with optional readback corruption, and immediate-assert checks.
module tb_snoop_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base;
    logic [8:0] len;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] err_addr;

    snoop_loader_if #(.AW(8), .DW(8)) bus ();

    snoop_loader #(
        .AW(8), .DW(8), .LW(9), .VERIFY(1), .READ_LAT(1), .SKIP_ZERO(1)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .base     (base),
        .len      (len),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_addr (err_addr)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned wr_count = 0;
    logic [15:0] sb [$];
    logic [7:0]  exp_addr;
    logic [7:0]  mem [256];
    bit          corrupt = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Snoop-side memory: writes on snoopw, one-cycle read latency on snoopm
    always @(posedge clk) begin
        if (bus.snoopw) mem[bus.snoopa] <= bus.snoopd;
        if (bus.snoopm) bus.snoopq <= (corrupt && bus.snoopa == 8'h05) ? 8'hFF : mem[bus.snoopa];
    end

    // Write monitor and core-hold coherence check
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pause_vs_core_reset", 32'(bus.snoopp), 32'(bus.core_reset));
            if (bus.snoopw) begin
                wr_count++;
                chk("write_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("write_addr_data", 32'({bus.snoopa, bus.snoopd}), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input bit rnd);
        int unsigned n;
        if (d != 8'h00) sb.push_back({exp_addr, d});
        exp_addr = exp_addr + 8'd1;
        if (rnd) begin
            while ($urandom_range(1, 0) == 1) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stream_accept", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("finish_in_time", 32'(done | error), 32'd1);
    endtask

    task automatic check_released(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_snoopp"}, 32'(bus.snoopp), 32'd0);
        chk({tag, "_core_reset"}, 32'(bus.core_reset), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_snoopa"}, 32'(bus.snoopa), 32'd0);
        chk({tag, "_snoopd"}, 32'(bus.snoopd), 32'd0);
        chk({tag, "_snoopm"}, 32'(bus.snoopm), 32'd0);
        chk({tag, "_snoopw"}, 32'(bus.snoopw), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_err_addr"}, 32'(err_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_snoopp"}, 32'(bus.snoopp), 32'd1);
        chk({tag, "_core_reset"}, 32'(bus.core_reset), 32'd1);
    endtask

    initial begin
        logic [7:0] img [13];
        logic [7:0] rnd_word;
        logic       seen_ready;
        int unsigned wr_before;

        img = '{8'h68, 8'h0c, 8'h34, 8'h03, 8'h4a, 8'h90, 8'h0c,
                8'h38, 8'h42, 8'h4a, 8'h4a, 8'h42, 8'ha8};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n        = 1'b0;
        start        = 1'b0;
        base         = 8'h00;
        len          = 9'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        exp_addr     = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full 13-word image with verify
        exp_addr = 8'h00;
        pulse_start(8'h00, 9'd13);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 13; i++) send_word(img[i], 1'b0);
        wait_end(20);
        check_released("image13");

        // Zero word consumes an address but is not written
        wr_before = wr_count;
        exp_addr  = 8'h10;
        pulse_start(8'h10, 9'd3);
        send_word(8'h11, 1'b0);
        send_word(8'h00, 1'b0);
        send_word(8'h22, 1'b0);
        wait_end(10);
        check_released("skip_zero");
        chk("skip_zero_writes", wr_count - wr_before, 32'd2);

        // Verify mismatch at address 5
        corrupt  = 1'b1;
        exp_addr = 8'h00;
        pulse_start(8'h00, 9'd13);
        for (int i = 0; i < 6; i++) send_word(img[i], 1'b0);
        wait_end(20);
        chk("mismatch_error", 32'(error), 32'd1);
        chk("mismatch_err_addr", 32'(err_addr), 32'h05);
        chk("mismatch_done", 32'(done), 32'd0);
        chk("mismatch_snoopp", 32'(bus.snoopp), 32'd1);
        chk("mismatch_core_reset", 32'(bus.core_reset), 32'd1);
        seen_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen_ready = seen_ready | bus.in_ready;
        end
        chk("mismatch_no_ready", 32'(seen_ready), 32'd0);
        chk("mismatch_sb_empty", 32'(sb.size()), 32'd0);
        corrupt = 1'b0;

        // Address wrap from FE through 01
        exp_addr = 8'hFE;
        pulse_start(8'hFE, 9'd4);
        chk("restart_clears_error", 32'(error), 32'd0);
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b0);
        send_word(8'h03, 1'b0);
        send_word(8'h04, 1'b0);
        wait_end(20);
        check_released("wrap");
        chk("wrap_mem_00", 32'(mem[8'h00]), 32'h03);
        chk("wrap_mem_01", 32'(mem[8'h01]), 32'h04);

        // Randomly gapped stream, with a start pulse while busy
        exp_addr = 8'h20;
        pulse_start(8'h20, 9'd10);
        for (int i = 0; i < 10; i++) begin
            rnd_word = 8'($urandom_range(255, 0));
            send_word(rnd_word, 1'b1);
            if (i == 3) begin
                pulse_start(8'h80, 9'd1);
                chk("start_ignored_busy", 32'(busy), 32'd1);
            end
        end
        wait_end(20);
        check_released("random");

        // Reset mid-load returns every output to its reset value at once
        exp_addr  = 8'h40;
        wr_before = wr_count;
        pulse_start(8'h40, 9'd8);
        send_word(8'h5A, 1'b0);
        send_word(8'h5B, 1'b0);
        send_word(8'h5C, 1'b0);
        for (int n = 0; n < 20 && wr_count < wr_before + 3; n++) @(negedge clk);
        chk("three_writes_before_reset", wr_count - wr_before, 32'd3);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midload_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-length load releases immediately
        wr_before = wr_count;
        pulse_start(8'h33, 9'd0);
        chk("len0_release_busy", 32'(busy), 32'd1);
        chk("len0_release_snoopp", 32'(bus.snoopp), 32'd0);
        chk("len0_release_done", 32'(done), 32'd0);
        @(negedge clk);
        check_released("len0");
        chk("len0_no_writes", wr_count - wr_before, 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snoop_loader.md
Name: snoop_loader

Overview:
- Parametrised program loader that drives the discus snoop port from a valid/ready byte stream.
- Holds the core paused and in reset, writes a contiguous image from a base address, optionally skips zero bytes, and optionally reads back each word for verification.
- On success it releases the core; on a verify mismatch it stops and latches the failing address.
- Sits between a host/UART byte source and the discus snoop interface, replacing hand-sequenced testbench loading.

Parameters:
- AW, 8, snoop address width.
- DW, 8, snoop data width.
- LW, 9, length counter width (max image = 2**LW-1 words).
- VERIFY, 1, 1 = read back and compare each written word.
- READ_LAT, 1, cycles from snoopa valid with snoopm=1 to snoopq valid (>=1).
- SKIP_ZERO, 1, 1 = zero data words consume an address but issue no write.

Ports:
- clk  in  1  system clock, also drives snoop_clk.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a load; ignored unless state is IDLE, DONE or ERROR.
- base  in  AW  first load address, sampled on start.
- len  in  LW  number of words, sampled on start; 0 = release immediately.
- in_valid  in  1  stream word valid.
- in_data  in  DW  stream word.
- in_ready  out  1  stream accept; a transfer occurs when in_valid & in_ready.
- snoopa  out  AW  snoop address.
- snoopd  out  DW  snoop write data.
- snoopm  out  1  0 = write strobe cycle, 1 = read cycle.
- snoopw  out  1  write enable, high for exactly one cycle per issued write.
- snoopq  in  DW  snoop read data.
- snoopp  out  1  core pause; high while loading.
- core_reset  out  1  active-high reset to the core; high while loading.
- busy  out  1  state is not IDLE, DONE or ERROR.
- done  out  1  level; load completed and core released.
- error  out  1  level; verify mismatch.
- err_addr  out  AW  address of the first mismatch.

Behaviour:
- Reset (reset=0, async) values: state=IDLE, in_ready=0, snoopa=0, snoopd=0, snoopm=0, snoopw=0, done=0, error=0, err_addr=0, snoopp=1, core_reset=1. The core stays held until the first successful load.
- States: IDLE, FETCH, WRITE, RDWAIT, CHECK, RELEASE, DONE, ERROR.
- IDLE/DONE/ERROR, on start:
  - Latch addr=base and cnt=len; clear done and error; drive snoopp=1 and core_reset=1.
  - If len=0, go to RELEASE; otherwise go to FETCH.
- FETCH:
  - in_ready=1; stays in FETCH until a transfer occurs.
  - On transfer, latch the data word.
  - If SKIP_ZERO and data==0: addr+=1 (wraps modulo 2**AW), cnt-=1, then go to RELEASE if cnt hits 0, else stay in FETCH.
  - Otherwise go to WRITE.
  - in_ready is 0 in every state except FETCH.
- WRITE (1 cycle):
  - snoopa=addr, snoopd=data, snoopm=0, snoopw=1.
  - If VERIFY, go to RDWAIT; otherwise addr+=1, cnt-=1, then go to RELEASE if cnt hits 0, else FETCH.
- RDWAIT:
  - snoopa=addr, snoopm=1, snoopw=0; hold for READ_LAT cycles, then go to CHECK.
- CHECK:
  - If snoopq==data: addr+=1, cnt-=1, then go to RELEASE or FETCH as in WRITE.
  - Otherwise: err_addr=addr, error=1, go to ERROR. The core remains held (snoopp=1, core_reset=1).
- RELEASE (1 cycle): core_reset=0, snoopp=0, then go to DONE with done=1.
- DONE: snoopp=0, core_reset=0 until the next start.
- Address wrap: addr wraps from 2**AW-1 to 0 without error.
- start while busy is ignored.
- reset asserted mid-load aborts immediately to reset values; a partially written image is left in memory.
- Throughput: without VERIFY, one word per 2 cycles at full stream rate. With VERIFY, one word per 3+READ_LAT cycles.

Test Plan:
- SKIP_ZERO=1, VERIFY=1, base=0, len=13, stream 68 0c 34 03 4a 90 0c 38 42 4a 4a 42 a8 -> 13 snoopw pulses at addresses 0..12 with matching snoopd; done=1; snoopp and core_reset fall together; no error.
- SKIP_ZERO=1, stream 11 00 22, base=0x10 -> writes only at 0x10 and 0x12; done=1 after the third accept.
- VERIFY=1, memory model forces readback at address 0x05 to 0xFF (written 0x90) -> error=1, err_addr=0x05, snoopp=1 and core_reset=1 held, no further in_ready.
- base=0xFE, len=4, data 01 02 03 04 -> writes to FE, FF, 00, 01.
- in_valid toggled randomly with 50% duty -> no word lost or duplicated; start pulsed while busy is ignored; reset dropped after 3 writes -> all outputs return to reset values within the same cycle.
- len=0 start -> RELEASE next cycle, done=1, zero snoopw pulses.
